debug_display_pager: RTL and testbench

DEBUG_DISPLAY_PAGER -- requirements
Module: debug_display_pager

---
 rtl/dbg_pkg.sv | 39 +++
 rtl/debug_debounce.sv | 126 ++++++++++++
 rtl/debug_display_pager.sv | 169 ++++++++++++++++
 tb/tb_debug_display_pager.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug display pager: segment table, blank pattern
// and step FSM state encodings.
package dbg_pkg;

    localparam logic [7:0] lp_blank   = 8'hFF;
    localparam logic [7:0] lp_dp_mask = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } step_state_t;

    // Active-low {dp,g,f,e,d,c,b,a} pattern for one hex nibble, dp off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = lp_blank;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/debug_debounce.sv
// Button synchroniser + stability debouncer producing a one-cycle press event.
// With DEBUG_AUTOREPEAT_EN defined, a repeat_en port adds hold-to-repeat events.
module debug_debounce
    import dbg_pkg::*;
#(
    parameter int p_debounce_cycles = 65536
) (
    input  logic clk,
    input  logic reset,
`ifdef DEBUG_AUTOREPEAT_EN
    input  logic repeat_en,
`endif
    input  logic button,
    output logic pulse
);

    localparam int lp_cnt_w = $clog2(p_debounce_cycles + 1);

    logic                sync1_r;
    logic                sync2_r;
    logic [lp_cnt_w-1:0] cnt_r;
    logic                level_r;
    logic                armed_r;
    logic                event_r;
    logic                accept_s;
    logic                rise_s;

    // Synchroniser is deliberately not reset so a button held through reset still reads high.
    always_ff @(posedge clk) begin
        sync1_r <= button;
        sync2_r <= sync1_r;
    end

    // A new level is accepted once it has differed from the current one for the full window.
    always_comb begin
        accept_s = 1'b0;
        if ((sync2_r != level_r) && (cnt_r == lp_cnt_w'(p_debounce_cycles - 1))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        rise_s = accept_s & sync2_r & armed_r;
    end

    // Stability counter, debounced level and arming (only after the button is seen released).
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            if ((sync2_r == level_r) || accept_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + lp_cnt_w'(1);
            end
            if (accept_s) begin
                level_r <= sync2_r;
            end
            if (!sync2_r) begin
                armed_r <= 1'b1;
            end
        end
    end

`ifdef DEBUG_AUTOREPEAT_EN
    localparam int lp_rpt_w = $clog2(8 * p_debounce_cycles + 1);

    logic [lp_rpt_w-1:0] rpt_cnt_r;
    logic                held_r;
    logic                first_r;
    logic                rpt_s;

    // First repeat after the long delay, later ones after the short delay.
    always_comb begin
        rpt_s = 1'b0;
        if (repeat_en && held_r && level_r) begin
            if (first_r) begin
                rpt_s = (rpt_cnt_r == lp_rpt_w'(8 * p_debounce_cycles - 1));
            end else begin
                rpt_s = (rpt_cnt_r == lp_rpt_w'(2 * p_debounce_cycles - 1));
            end
        end else begin
            rpt_s = 1'b0;
        end
    end

    // Event register with hold tracking for autorepeat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rpt_cnt_r <= '0;
            held_r    <= 1'b0;
            first_r   <= 1'b0;
            event_r   <= 1'b0;
        end else if (rise_s) begin
            rpt_cnt_r <= '0;
            held_r    <= 1'b1;
            first_r   <= 1'b1;
            event_r   <= 1'b1;
        end else if (rpt_s) begin
            rpt_cnt_r <= '0;
            first_r   <= 1'b0;
            event_r   <= 1'b1;
        end else if (held_r && level_r) begin
            rpt_cnt_r <= rpt_cnt_r + lp_rpt_w'(1);
            event_r   <= 1'b0;
        end else begin
            rpt_cnt_r <= '0;
            held_r    <= 1'b0;
            event_r   <= 1'b0;
        end
    end
`else
    // One event per accepted rising level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            event_r <= 1'b0;
        end else begin
            event_r <= rise_s;
        end
    end
`endif

    assign pulse = event_r;

endmodule

// File: rtl/debug_display_pager.sv
// Pages debug words onto a multiplexed seven-segment display and single-steps a CPU clock.
// Optional macro DEBUG_AUTOREPEAT_EN enables hold-to-repeat on next/prev.
module debug_display_pager
    import dbg_pkg::*;
#(
    parameter int p_data_width      = 16,
    parameter int p_no_words        = 8,
    parameter int p_digits          = 8,
    parameter int p_divisor         = 50000,
    parameter int p_debounce_cycles = 65536,
    parameter int p_no_cycles       = 1
) (
    input  logic                               i_w_clk,
    input  logic                               i_w_reset,
    input  logic [p_no_words*p_data_width-1:0] i_w_data,
    input  logic                               i_w_next,
    input  logic                               i_w_prev,
    input  logic                               i_w_step,
    output logic [7:0]                         o_w_7_led_seg,
    output logic [p_digits-1:0]                o_w_an,
    output logic                               o_w_sim_clk,
    output logic [7:0]                         o_w_page
);

    localparam int lp_hex_digits = p_data_width / 4;
    localparam int lp_dig_w      = $clog2(p_digits);
    localparam int lp_div_w      = $clog2(p_divisor);
    localparam int lp_step_w     = (p_no_cycles > 1) ? $clog2(p_no_cycles) : 1;
    localparam int lp_page_w     = $clog2(p_no_words);

    logic                     next_ev_s;
    logic                     prev_ev_s;
    logic                     step_ev_s;
    logic [7:0]               page_r;
    step_state_t              state_r;
    logic [lp_step_w-1:0]     step_cnt_r;
    logic                     sim_clk_r;
    logic [lp_div_w-1:0]      div_r;
    logic [lp_dig_w-1:0]      digit_r;
    logic [lp_dig_w-1:0]      digit_next_s;
    logic [p_data_width-1:0]  word_s;
    logic [7:0]               seg_s;
    logic [p_digits-1:0]      one_hot_s;
    logic [7:0]               seg_r;
    logic [p_digits-1:0]      an_r;

    debug_debounce #(.p_debounce_cycles(p_debounce_cycles)) u_next (
        .clk(i_w_clk), .reset(i_w_reset),
`ifdef DEBUG_AUTOREPEAT_EN
        .repeat_en(1'b1),
`endif
        .button(i_w_next), .pulse(next_ev_s)
    );

    debug_debounce #(.p_debounce_cycles(p_debounce_cycles)) u_prev (
        .clk(i_w_clk), .reset(i_w_reset),
`ifdef DEBUG_AUTOREPEAT_EN
        .repeat_en(1'b1),
`endif
        .button(i_w_prev), .pulse(prev_ev_s)
    );

    debug_debounce #(.p_debounce_cycles(p_debounce_cycles)) u_step (
        .clk(i_w_clk), .reset(i_w_reset),
`ifdef DEBUG_AUTOREPEAT_EN
        .repeat_en(1'b0),
`endif
        .button(i_w_step), .pulse(step_ev_s)
    );

    // Page selection; simultaneous next and prev cancel out.
    always_ff @(posedge i_w_clk) begin
        if (!i_w_reset) begin
            page_r <= 8'd0;
        end else if (next_ev_s && !prev_ev_s) begin
            page_r <= (page_r == 8'(p_no_words - 1)) ? 8'd0 : page_r + 8'd1;
        end else if (prev_ev_s && !next_ev_s) begin
            page_r <= (page_r == 8'd0) ? 8'(p_no_words - 1) : page_r - 8'd1;
        end else begin
            page_r <= page_r;
        end
    end

    // Single-step FSM; step events while busy are dropped.
    always_ff @(posedge i_w_clk) begin
        if (!i_w_reset) begin
            state_r    <= ST_IDLE;
            step_cnt_r <= '0;
            sim_clk_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (step_ev_s) begin
                        state_r    <= ST_HIGH;
                        sim_clk_r  <= 1'b1;
                        step_cnt_r <= '0;
                    end
                end
                ST_HIGH: begin
                    if (step_cnt_r == lp_step_w'(p_no_cycles - 1)) begin
                        state_r    <= ST_LOW;
                        sim_clk_r  <= 1'b0;
                        step_cnt_r <= '0;
                    end else begin
                        step_cnt_r <= step_cnt_r + lp_step_w'(1);
                    end
                end
                ST_LOW: begin
                    if (step_cnt_r == lp_step_w'(p_no_cycles - 1)) begin
                        state_r    <= ST_IDLE;
                        step_cnt_r <= '0;
                    end else begin
                        step_cnt_r <= step_cnt_r + lp_step_w'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    sim_clk_r  <= 1'b0;
                    step_cnt_r <= '0;
                end
            endcase
        end
    end

    // Pattern for the digit about to be shown; the word is sampled as the slot changes.
    always_comb begin
        digit_next_s = (digit_r == lp_dig_w'(p_digits - 1)) ? lp_dig_w'(0) : digit_r + lp_dig_w'(1);
        one_hot_s    = {{(p_digits - 1){1'b0}}, 1'b1} << digit_next_s;
        word_s       = i_w_data[int'(page_r[lp_page_w-1:0]) * p_data_width +: p_data_width];
        seg_s        = lp_blank;
        if (int'(digit_next_s) < lp_hex_digits) begin
            seg_s = hex_to_seg(4'(word_s >> (4 * int'(digit_next_s))));
        end else if (int'(digit_next_s) == p_digits - 2) begin
            seg_s = hex_to_seg(page_r[3:0]);
        end else if (int'(digit_next_s) == p_digits - 1) begin
            seg_s = hex_to_seg(page_r[7:4]);
        end else begin
            seg_s = lp_blank;
        end
        if (int'(digit_next_s) == lp_hex_digits) begin
            seg_s = seg_s & lp_dp_mask;
        end else begin
            seg_s = seg_s;
        end
    end

    // Scan divider and registered segment/anode outputs, updated together.
    always_ff @(posedge i_w_clk) begin
        if (!i_w_reset) begin
            div_r   <= '0;
            digit_r <= '0;
            an_r    <= '1;
            seg_r   <= lp_blank;
        end else if (div_r == lp_div_w'(p_divisor - 1)) begin
            div_r   <= '0;
            digit_r <= digit_next_s;
            an_r    <= ~one_hot_s;
            seg_r   <= seg_s;
        end else begin
            div_r   <= div_r + lp_div_w'(1);
        end
    end

    assign o_w_7_led_seg = seg_r;
    assign o_w_an        = an_r;
    assign o_w_sim_clk   = sim_clk_r;
    assign o_w_page      = page_r;

endmodule

// File: tb/tb_debug_display_pager.sv
// Self-checking bench for debug_display_pager: directed + randomized paging,
// display contents, single-step pulse, reset behaviour and debouncing.
module tb_debug_display_pager;

    localparam int W   = 16;
    localparam int N   = 8;
    localparam int D   = 8;
    localparam int DIV = 4;
    localparam int DEB = 4;
    localparam int NC  = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] data;
    logic           nxt, prv, stp;
    logic [7:0]     seg;
    logic [D-1:0]   an;
    logic           sim_clk;
    logic [7:0]     page;

    int total = 0;
    int bad   = 0;
    int model_page = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    debug_display_pager #(
        .p_data_width(W), .p_no_words(N), .p_digits(D),
        .p_divisor(DIV), .p_debounce_cycles(DEB), .p_no_cycles(NC)
    ) dut (
        .i_w_clk(clk), .i_w_reset(rst_n), .i_w_data(data),
        .i_w_next(nxt), .i_w_prev(prv), .i_w_step(stp),
        .o_w_7_led_seg(seg), .o_w_an(an), .o_w_sim_clk(sim_clk), .o_w_page(page)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // which: 0 next, 1 prev, 2 step, 3 next+prev together
    task automatic press(input int which, input int hold);
        @(negedge clk);
        nxt = (which == 0 || which == 3);
        prv = (which == 1 || which == 3);
        stp = (which == 2);
        repeat (hold) @(negedge clk);
        nxt = 1'b0; prv = 1'b0; stp = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    function automatic logic [7:0] exp_seg(input int d);
        logic [W-1:0] w;
        logic [7:0]   s;
        w = data[model_page*W +: W];
        s = 8'hFF;
        if (d < W/4)         s = seg_tab[int'((w >> (4*d)) & 16'hF)];
        else if (d == D - 2) s = seg_tab[model_page % 16];
        else if (d == D - 1) s = seg_tab[model_page / 16];
        if (d == W/4) s = s & 8'h7F;
        return s;
    endfunction

    task automatic check_display(input string tag);
        int idx;
        repeat (2*DIV) @(negedge clk);
        for (int c = 0; c < D*DIV; c++) begin
            @(negedge clk);
            check({tag, "_an_onehot"}, 32'($countones(~an)), 32'd1);
            idx = 0;
            for (int k = 0; k < D; k++) if (!an[k]) idx = k;
            check({tag, "_seg"}, 32'(seg), 32'(exp_seg(idx)));
        end
    endtask

    task automatic check_digit(input int d, input logic [7:0] lit);
        logic [D-1:0] target;
        target = ~(8'd1 << d);
        for (int i = 0; i < 4*D*DIV; i++) begin
            @(negedge clk);
            if (an == target) break;
        end
        check($sformatf("beef_d%0d_an", d), 32'(an), 32'(target));
        check($sformatf("beef_d%0d_seg", d), 32'(seg), 32'(lit));
    endtask

    initial begin
        int highs, rises, seen;
        logic last;
        rst_n = 1'b0; nxt = 1'b0; prv = 1'b0; stp = 1'b0;
        for (int k = 0; k < N; k++) data[k*W +: W] = W'($urandom);
        repeat (5) @(negedge clk);
        check("rst_an",   32'(an), 32'hFF);
        check("rst_seg",  32'(seg), 32'hFF);
        check("rst_sim",  32'(sim_clk), 32'd0);
        check("rst_page", 32'(page), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // eight next presses walk 1..7 then wrap to 0
        for (int i = 0; i < 8; i++) begin
            press(0, 10);
            model_page = (model_page + 1) % N;
            check($sformatf("next_%0d", i), 32'(page), 32'(model_page));
        end
        press(1, 10);
        model_page = (model_page + N - 1) % N;
        check("prev_wrap", 32'(page), 32'(model_page));
        press(3, 10);
        check("next_prev_same", 32'(page), 32'(model_page));

        // randomized paging with random words, checked against the model
        for (int it = 0; it < 6; it++) begin
            int n, dir;
            for (int k = 0; k < N; k++) data[k*W +: W] = W'($urandom);
            n   = $urandom_range(1, 4);
            dir = $urandom_range(0, 1);
            for (int p = 0; p < n; p++) begin
                press(dir, 10);
                model_page = (dir == 0) ? (model_page + 1) % N : (model_page + N - 1) % N;
            end
            check($sformatf("rand_page_%0d", it), 32'(page), 32'(model_page));
            check_display($sformatf("rand_disp_%0d", it));
        end

        // word 3 = BEEF on page 3
        data[3*W +: W] = 16'hBEEF;
        while (model_page != 3) begin
            press(0, 10);
            model_page = (model_page + 1) % N;
        end
        check("beef_page", 32'(page), 32'd3);
        check_display("beef");
        check_digit(0, 8'h8E);
        check_digit(1, 8'h86);
        check_digit(3, 8'h83);
        check_digit(4, 8'h7F);
        check_digit(5, 8'hFF);
        check_digit(6, 8'hB0);
        check_digit(7, 8'hC0);

        // single step gives exactly one pulse of NC cycles
        highs = 0; rises = 0; last = 1'b0;
        @(negedge clk);
        stp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 10) stp = 1'b0;
            if (sim_clk) highs++;
            if (sim_clk && !last) rises++;
            last = sim_clk;
        end
        check("step_high_cycles", 32'(highs), 32'(NC));
        check("step_pulses", 32'(rises), 32'd1);

        // bouncing next then a steady hold gives one increment
        for (int i = 0; i < 10; i++) begin
            nxt = ~nxt;
            repeat (2) @(negedge clk);
        end
        nxt = 1'b1;
        repeat (20) @(negedge clk);
        nxt = 1'b0;
        repeat (20) @(negedge clk);
        model_page = (model_page + 1) % N;
        check("bounce_once", 32'(page), 32'(model_page));

`ifdef DEBUG_AUTOREPEAT_EN
        begin
            int times[$];
            logic [7:0] lp;
            lp = page;
            nxt = 1'b1;
            for (int t = 0; t < 120; t++) begin
                @(negedge clk);
                if (t == 100) nxt = 1'b0;
                if (page != lp) begin
                    times.push_back(t);
                    lp = page;
                end
            end
            check("rpt_count_min", 32'(times.size() >= 8), 32'd1);
            if (times.size() >= 2) check("rpt_first_gap", 32'(times[1] - times[0]), 32'd32);
            for (int i = 2; i < times.size(); i++)
                check($sformatf("rpt_gap_%0d", i), 32'(times[i] - times[i-1]), 32'd8);
            model_page = (model_page + times.size()) % N;
            check("rpt_page", 32'(page), 32'(model_page));
        end
`else
        nxt = 1'b1;
        repeat (100) @(negedge clk);
        nxt = 1'b0;
        repeat (20) @(negedge clk);
        model_page = (model_page + 1) % N;
        check("hold_once", 32'(page), 32'(model_page));
`endif

        // reset during the high phase drops the step clock on the next edge
        stp = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sim_clk) begin
                seen = 1;
                break;
            end
        end
        check("mid_step_seen_high", 32'(seen), 32'd1);
        rst_n = 1'b0;
        stp = 1'b0;
        @(posedge clk);
        #1;
        model_page = 0;
        check("mid_rst_sim", 32'(sim_clk), 32'd0);
        check("mid_rst_an", 32'(an), 32'hFF);
        check("mid_rst_seg", 32'(seg), 32'hFF);
        check("mid_rst_page", 32'(page), 32'd0);

        // next held across reset release must not page
        @(negedge clk);
        nxt = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("held_across_rst", 32'(page), 32'd0);
        nxt = 1'b0;
        repeat (20) @(negedge clk);
        press(0, 10);
        model_page = 1;
        check("after_rst_press", 32'(page), 32'(model_page));
        check_display("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
